// File: rtl/hazard_stall_controller.sv
// Hazard detection and stall/flush sequencing for the 5-stage MIPS pipeline.
// Optional statistics counters are enabled with `define HAZARD_STATS_EN.
module hazard_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IF_ID_RS,
  input  logic [4:0] IF_ID_RT,
  input  logic       IF_ID_USES_RT,
  input  logic       IF_ID_BRANCH,
  input  logic       BRANCH_TAKEN,
  input  logic [4:0] ID_EX_WRITE_REG,
  input  logic       ID_EX_REGWRITE,
  input  logic       ID_EX_MEMREAD,
  input  logic [4:0] EX_MEM_WRITE_REG,
  input  logic       EX_MEM_MEMREAD,
  input  logic       MEM_BUSY,
  output logic       PC_WRITE,
  output logic       IF_ID_WRITE,
  output logic       IF_ID_FLUSH,
  output logic       ID_EX_BUBBLE,
  output logic       EX_MEM_WRITE,
  output logic       MEM_WB_BUBBLE,
  output logic       MEM_ERROR,
  output logic [1:0] STATE
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] STALL_COUNT,
  output logic [CNT_W-1:0] FLUSH_COUNT
`endif
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] HOLD     = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             err_set;
  logic             ex_nz, mem_nz;
  logic             lu, br_ex, br_mem;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  assign ex_nz  = (ID_EX_WRITE_REG != 5'd0);
  assign mem_nz = (EX_MEM_WRITE_REG != 5'd0);

  assign lu = ID_EX_MEMREAD && ex_nz &&
              ((ID_EX_WRITE_REG == IF_ID_RS) ||
               (IF_ID_USES_RT && (ID_EX_WRITE_REG == IF_ID_RT)));

  assign br_ex = IF_ID_BRANCH && ID_EX_REGWRITE && ex_nz &&
                 ((ID_EX_WRITE_REG == IF_ID_RS) || (ID_EX_WRITE_REG == IF_ID_RT));

  assign br_mem = IF_ID_BRANCH && EX_MEM_MEMREAD && mem_nz &&
                  ((EX_MEM_WRITE_REG == IF_ID_RS) || (EX_MEM_WRITE_REG == IF_ID_RT));

  always_comb begin
    PC_WRITE      = 1'b1;
    IF_ID_WRITE   = 1'b1;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_BUBBLE  = 1'b0;
    EX_MEM_WRITE  = 1'b1;
    MEM_WB_BUBBLE = 1'b0;
    state_next    = state;
    wait_cnt_next = wait_cnt;
    err_set       = 1'b0;

    if (!reset) begin
      case (state)
        RUN, HOLD: begin
          if (MEM_BUSY) begin
            PC_WRITE      = 1'b0;
            IF_ID_WRITE   = 1'b0;
            EX_MEM_WRITE  = 1'b0;
            MEM_WB_BUBBLE = 1'b1;
            wait_cnt_next = CNT_W'(1);
            state_next    = MEM_WAIT;
          end else if (state == HOLD) begin
            PC_WRITE     = 1'b0;
            IF_ID_WRITE  = 1'b0;
            ID_EX_BUBBLE = 1'b1;
            state_next   = RUN;
          end else if (lu || br_ex || br_mem) begin
            PC_WRITE     = 1'b0;
            IF_ID_WRITE  = 1'b0;
            ID_EX_BUBBLE = 1'b1;
            // A load feeding an ID-stage compare needs a second bubble.
            if (lu && IF_ID_BRANCH) state_next = HOLD;
          end else if (BRANCH_TAKEN) begin
            IF_ID_FLUSH = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (MEM_BUSY && (wait_cnt < CNT_W'(MEM_TIMEOUT))) begin
            PC_WRITE      = 1'b0;
            IF_ID_WRITE   = 1'b0;
            EX_MEM_WRITE  = 1'b0;
            MEM_WB_BUBBLE = 1'b1;
            wait_cnt_next = wait_cnt + CNT_W'(1);
          end else begin
            err_set       = MEM_BUSY;
            wait_cnt_next = '0;
            state_next    = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      MEM_ERROR <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (err_set) MEM_ERROR <= 1'b1;
    end
  end

  assign STATE = state;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      STALL_COUNT <= '0;
      FLUSH_COUNT <= '0;
    end else begin
      if (!PC_WRITE && (STALL_COUNT != '1)) STALL_COUNT <= STALL_COUNT + CNT_W'(1);
      if (IF_ID_FLUSH && (FLUSH_COUNT != '1)) FLUSH_COUNT <= FLUSH_COUNT + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: directed vectors push expected
// outputs, a negedge monitor pops and compares them.
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IF_ID_RS, IF_ID_RT, ID_EX_WRITE_REG, EX_MEM_WRITE_REG;
  logic       IF_ID_USES_RT, IF_ID_BRANCH, BRANCH_TAKEN;
  logic       ID_EX_REGWRITE, ID_EX_MEMREAD, EX_MEM_MEMREAD, MEM_BUSY;
  logic       PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE;
  logic       EX_MEM_WRITE, MEM_WB_BUBBLE, MEM_ERROR;
  logic [1:0] STATE;
`ifdef HAZARD_STATS_EN
  logic [7:0] STALL_COUNT, FLUSH_COUNT;
`endif

  always #5 clk = ~clk;

  hazard_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_RS(IF_ID_RS), .IF_ID_RT(IF_ID_RT), .IF_ID_USES_RT(IF_ID_USES_RT),
    .IF_ID_BRANCH(IF_ID_BRANCH), .BRANCH_TAKEN(BRANCH_TAKEN),
    .ID_EX_WRITE_REG(ID_EX_WRITE_REG), .ID_EX_REGWRITE(ID_EX_REGWRITE),
    .ID_EX_MEMREAD(ID_EX_MEMREAD), .EX_MEM_WRITE_REG(EX_MEM_WRITE_REG),
    .EX_MEM_MEMREAD(EX_MEM_MEMREAD), .MEM_BUSY(MEM_BUSY),
    .PC_WRITE(PC_WRITE), .IF_ID_WRITE(IF_ID_WRITE), .IF_ID_FLUSH(IF_ID_FLUSH),
    .ID_EX_BUBBLE(ID_EX_BUBBLE), .EX_MEM_WRITE(EX_MEM_WRITE),
    .MEM_WB_BUBBLE(MEM_WB_BUBBLE), .MEM_ERROR(MEM_ERROR), .STATE(STATE)
`ifdef HAZARD_STATS_EN
    , .STALL_COUNT(STALL_COUNT), .FLUSH_COUNT(FLUSH_COUNT)
`endif
  );

  // {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_WRITE, MEM_WB_BUBBLE}
  localparam logic [5:0] DEF = 6'b110010;
  localparam logic [5:0] STL = 6'b000110;
  localparam logic [5:0] FRZ = 6'b000001;
  localparam logic [5:0] FLS = 6'b111010;

  typedef struct {
    logic [8:0] v;
    string      n;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_stalls = 0;
  int   exp_flushes = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e   = q.pop_front();
      act = {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_WRITE,
             MEM_WB_BUBBLE, MEM_ERROR, STATE};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b (outs6,err,state)", e.n, act, e.v);
      end
    end
  end

  task automatic clr();
    IF_ID_RS = 5'd0; IF_ID_RT = 5'd0; IF_ID_USES_RT = 1'b0;
    IF_ID_BRANCH = 1'b0; BRANCH_TAKEN = 1'b0;
    ID_EX_WRITE_REG = 5'd0; ID_EX_REGWRITE = 1'b0; ID_EX_MEMREAD = 1'b0;
    EX_MEM_WRITE_REG = 5'd0; EX_MEM_MEMREAD = 1'b0; MEM_BUSY = 1'b0;
  endtask

  // Inputs are already driven for this cycle; record the expectation and advance.
  task automatic chk(input logic [5:0] o, input logic err, input logic [1:0] st,
                     input string name);
    exp_t e;
    e.v = {o, err, st};
    e.n = name;
    q.push_back(e);
    if (reset) begin
      exp_stalls  = 0;
      exp_flushes = 0;
    end else begin
      if (!o[5]) exp_stalls++;
      if (o[3]) exp_flushes++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lu_branch();
    clr();
    ID_EX_MEMREAD = 1'b1; ID_EX_WRITE_REG = 5'd8;
    IF_ID_BRANCH = 1'b1; IF_ID_RT = 5'd8; IF_ID_USES_RT = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk(DEF, 1'b0, 2'd0, "reset");
    reset = 1'b0;

    // Load-use into a plain ALU op: one bubble, stays in RUN.
    ID_EX_MEMREAD = 1'b1; ID_EX_WRITE_REG = 5'd8; IF_ID_RS = 5'd8;
    chk(STL, 1'b0, 2'd0, "lu_rs");
    clr();
    chk(DEF, 1'b0, 2'd0, "lu_after");

    // Load feeding a branch: two stall cycles, STATE 0,1,0; taken ignored while stalled.
    lu_branch();
    chk(STL, 1'b0, 2'd0, "lub_1");
    clr();
    IF_ID_BRANCH = 1'b1; IF_ID_RT = 5'd8; IF_ID_USES_RT = 1'b1;
    EX_MEM_MEMREAD = 1'b1; EX_MEM_WRITE_REG = 5'd8; BRANCH_TAKEN = 1'b1;
    chk(STL, 1'b0, 2'd1, "lub_hold");
    clr();
    IF_ID_BRANCH = 1'b1; IF_ID_RT = 5'd8; IF_ID_USES_RT = 1'b1;
    chk(DEF, 1'b0, 2'd0, "lub_done");

    // Register 0 and unused rt never match.
    clr();
    ID_EX_MEMREAD = 1'b1; ID_EX_WRITE_REG = 5'd0; IF_ID_RS = 5'd0;
    chk(DEF, 1'b0, 2'd0, "reg0");
    clr();
    ID_EX_MEMREAD = 1'b1; ID_EX_WRITE_REG = 5'd9; IF_ID_RT = 5'd9;
    chk(DEF, 1'b0, 2'd0, "rt_unused");

    // Branch operand produced in EX or loaded in MEM.
    clr();
    IF_ID_BRANCH = 1'b1; ID_EX_REGWRITE = 1'b1; ID_EX_WRITE_REG = 5'd5; IF_ID_RT = 5'd5;
    chk(STL, 1'b0, 2'd0, "br_ex");
    clr();
    IF_ID_BRANCH = 1'b1; EX_MEM_MEMREAD = 1'b1; EX_MEM_WRITE_REG = 5'd7; IF_ID_RS = 5'd7;
    chk(STL, 1'b0, 2'd0, "br_mem");

    // Taken branch flush, and its suppression under load-use.
    clr();
    IF_ID_BRANCH = 1'b1; BRANCH_TAKEN = 1'b1;
    chk(FLS, 1'b0, 2'd0, "flush");
    clr();
    BRANCH_TAKEN = 1'b1; ID_EX_MEMREAD = 1'b1; ID_EX_WRITE_REG = 5'd3; IF_ID_RS = 5'd3;
    chk(STL, 1'b0, 2'd0, "flush_lu");

    // Three busy cycles with a load-use present: busy wins, release ignores hazards.
    clr();
    MEM_BUSY = 1'b1; ID_EX_MEMREAD = 1'b1; ID_EX_WRITE_REG = 5'd3; IF_ID_RS = 5'd3;
    chk(FRZ, 1'b0, 2'd0, "busy_1");
    chk(FRZ, 1'b0, 2'd2, "busy_2");
    chk(FRZ, 1'b0, 2'd2, "busy_3");
    MEM_BUSY = 1'b0;
    chk(DEF, 1'b0, 2'd2, "busy_release");
    clr();
    chk(DEF, 1'b0, 2'd0, "busy_run");

    // Ten busy cycles with MEM_TIMEOUT=4: forced release, re-freeze, sticky error.
    MEM_BUSY = 1'b1;
    chk(FRZ, 1'b0, 2'd0, "to_1");
    chk(FRZ, 1'b0, 2'd2, "to_2");
    chk(FRZ, 1'b0, 2'd2, "to_3");
    chk(FRZ, 1'b0, 2'd2, "to_4");
    chk(DEF, 1'b0, 2'd2, "to_release");
    chk(FRZ, 1'b1, 2'd0, "to_6");
    chk(FRZ, 1'b1, 2'd2, "to_7");
    chk(FRZ, 1'b1, 2'd2, "to_8");
    chk(FRZ, 1'b1, 2'd2, "to_9");
    chk(DEF, 1'b1, 2'd2, "to_10");
    MEM_BUSY = 1'b0;
    chk(DEF, 1'b1, 2'd0, "err_sticky");

    // Busy during HOLD abandons the hold.
    lu_branch();
    chk(STL, 1'b1, 2'd0, "hb_1");
    clr();
    MEM_BUSY = 1'b1;
    chk(FRZ, 1'b1, 2'd1, "hb_busy");
    MEM_BUSY = 1'b0;
    chk(DEF, 1'b1, 2'd2, "hb_release");
    chk(DEF, 1'b1, 2'd0, "hb_run");

    // Reset during MEM_WAIT and during HOLD.
    MEM_BUSY = 1'b1;
    chk(FRZ, 1'b1, 2'd0, "rw_1");
    chk(FRZ, 1'b1, 2'd2, "rw_2");
    reset = 1'b1;
    chk(DEF, 1'b1, 2'd2, "rw_reset");
    reset = 1'b0;
    MEM_BUSY = 1'b0;
    chk(DEF, 1'b0, 2'd0, "rw_after");
    lu_branch();
    chk(STL, 1'b0, 2'd0, "rh_1");
    reset = 1'b1;
    chk(DEF, 1'b0, 2'd1, "rh_reset");
    reset = 1'b0;
    clr();
    IF_ID_BRANCH = 1'b1; BRANCH_TAKEN = 1'b1;
    chk(FLS, 1'b0, 2'd0, "rh_after");
    clr();
    chk(DEF, 1'b0, 2'd0, "final");

    repeat (4) begin
      if (q.size() != 0) @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if (STALL_COUNT !== 8'(exp_stalls)) begin
      errors++;
      $display("FAIL stall_count: got %0d want %0d", STALL_COUNT, exp_stalls);
    end
    checks++;
    if (FLUSH_COUNT !== 8'(exp_flushes)) begin
      errors++;
      $display("FAIL flush_count: got %0d want %0d", FLUSH_COUNT, exp_flushes);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; pairs with the forwarding unit.
- Detects hazards that forwarding cannot cover: load-use, branch-in-ID operand dependencies, data-memory wait states and taken-branch flush.
- Drives the write enables, bubble controls and flush controls of the PC and all pipeline registers.
- Small FSM sequences multi-cycle stalls and memory waits, with a wait timeout.

Parameters:
- MEM_TIMEOUT, 16: max consecutive MEM_BUSY cycles before forced release (range 1..255).
- CNT_W, 8: width of the wait counter and of the optional statistics counters.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- IF_ID_RS  in  5  rs of the instruction in ID
- IF_ID_RT  in  5  rt of the instruction in ID
- IF_ID_USES_RT  in  1  ID instruction reads rt as a source
- IF_ID_BRANCH  in  1  ID instruction is beq/bne (compared in ID)
- BRANCH_TAKEN  in  1  ID-stage branch resolved taken this cycle
- ID_EX_WRITE_REG  in  5  destination register of the EX instruction
- ID_EX_REGWRITE  in  1  EX instruction writes a register
- ID_EX_MEMREAD  in  1  EX instruction is a load
- EX_MEM_WRITE_REG  in  5  destination register of the MEM instruction
- EX_MEM_MEMREAD  in  1  MEM instruction is a load
- MEM_BUSY  in  1  data memory not ready this cycle
- PC_WRITE  out  1  PC update enable
- IF_ID_WRITE  out  1  IF/ID register load enable
- IF_ID_FLUSH  out  1  zero IF/ID (squash fetched instruction)
- ID_EX_BUBBLE  out  1  load NOP control into ID/EX
- EX_MEM_WRITE  out  1  EX/MEM and ID/EX load enable
- MEM_WB_BUBBLE  out  1  load NOP control into MEM/WB
- MEM_ERROR  out  1  sticky flag: memory wait timed out
- STATE  out  2  current FSM state (debug)

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- States: RUN=0, HOLD=1, MEM_WAIT=2; the encoding 3 is unused and returns to RUN.
- Reset sets state RUN, wait counter 0, MEM_ERROR 0.
- Outputs are combinational (Mealy) from state and inputs, so a stall takes effect in the same cycle the hazard is seen.
- Default outputs: PC_WRITE=1, IF_ID_WRITE=1, EX_MEM_WRITE=1, all bubble and flush outputs 0.
- Outputs hold these defaults while reset is high.
- Hazard terms (register 0 never matches):
  - LU: ID_EX_MEMREAD and ID_EX_WRITE_REG equals IF_ID_RS, or equals IF_ID_RT when IF_ID_USES_RT.
  - BR_EX: IF_ID_BRANCH and ID_EX_REGWRITE and ID_EX_WRITE_REG matches RS or RT.
  - BR_MEM: IF_ID_BRANCH and EX_MEM_MEMREAD and EX_MEM_WRITE_REG matches RS or RT.
- Priority in RUN: MEM_BUSY > LU > BR_EX or BR_MEM > BRANCH_TAKEN.
- RUN, MEM_BUSY: freeze. PC_WRITE=0, IF_ID_WRITE=0, EX_MEM_WRITE=0, MEM_WB_BUBBLE=1. Load wait counter with 1, go to MEM_WAIT.
- RUN, LU with IF_ID_BRANCH: stall (PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1), go to HOLD. The load needs 2 stall cycles in total.
- RUN, LU without branch, or BR_EX, or BR_MEM: single stall cycle, stay in RUN.
- RUN, BRANCH_TAKEN with no stall: IF_ID_FLUSH=1. BRANCH_TAKEN is ignored in any stalled cycle.
- HOLD: unconditional stall cycle, no hazard re-evaluation, then return to RUN.
  - MEM_BUSY in HOLD takes priority: freeze and go to MEM_WAIT. HOLD is not resumed afterwards; re-detection in RUN covers any remaining stall.
- MEM_WAIT: freeze outputs while MEM_BUSY; increment the wait counter each cycle.
  - When the counter reaches MEM_TIMEOUT with MEM_BUSY still high: set MEM_ERROR, release (default outputs), go to RUN.
  - MEM_BUSY low: release in that cycle, counter to 0, go to RUN. Hazards are not evaluated on the release cycle.
- MEM_ERROR is sticky until reset.
- Reset mid-stall or mid-wait aborts immediately to RUN with no residual stall.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds output ports STALL_COUNT[CNT_W-1:0] and FLUSH_COUNT[CNT_W-1:0].
  - STALL_COUNT increments on every cycle with PC_WRITE=0.
  - FLUSH_COUNT increments on every IF_ID_FLUSH=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- lw $t0 in EX (ID_EX_MEMREAD=1, ID_EX_WRITE_REG=8), add with IF_ID_RS=8 in ID -> one cycle PC_WRITE=0, ID_EX_BUBBLE=1, STATE stays 0.
- Same load, beq in ID with IF_ID_RT=8, IF_ID_USES_RT=1 -> 2 stall cycles; STATE sequence 0,1,0.
- ID_EX_WRITE_REG=0, ID_EX_MEMREAD=1, IF_ID_RS=0 -> no stall (all defaults).
- MEM_BUSY high 3 cycles -> 3 freeze cycles (EX_MEM_WRITE=0, MEM_WB_BUBBLE=1), STATE=2, release on the 4th cycle, MEM_ERROR=0.
- MEM_TIMEOUT=4, MEM_BUSY held high 10 cycles -> MEM_ERROR=1 after the 4th wait cycle, STATE returns to 0, flag holds until reset.
- BRANCH_TAKEN=1 with no hazard -> IF_ID_FLUSH=1 for 1 cycle; BRANCH_TAKEN=1 together with LU -> stall only, IF_ID_FLUSH=0; reset asserted during MEM_WAIT -> STATE=0 next cycle.
